// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared types, defaults and helpers for the fetch pc unit
package fetch_pc_unit_pkg;

  localparam int unsigned FETCH_ADDR_W   = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  // A fetch address is misaligned when either of its two low bits is set.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - pipeline-control and ROM-side signal bundle of the fetch pc unit
interface fetch_pc_unit_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  logic              addr_err;
  logic              pend_valid;

  // Pipeline control side: issues stall/flush/branch, observes the fetch stream.
  modport master (
    output stall, flush, new_pc, branch_flag, branch_target,
    input  pc, ce, if_pc, if_valid, addr_err, pend_valid
  );

  // Fetch unit side.
  modport slave (
    input  stall, flush, new_pc, branch_flag, branch_target,
    output pc, ce, if_pc, if_valid, addr_err, pend_valid
  );

endinterface

// File: rtl/fetch_pc_unit_redirect_buf.sv
// rtl/fetch_pc_unit_redirect_buf.sv - one-entry branch redirect buffer and next-pc priority mux
module fetch_redirect_buf
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_new_pc,
  input  logic              i_branch_flag,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic              o_pend_valid
);

  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] w_next_pc;

  // Capture a branch that resolves while stalled; any non-stalled RUN edge
  // either consumes the entry or supersedes it, so it is cleared there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (i_run) begin
      if (i_flush) begin
        r_pend_valid <= 1'b0;
      end else if (i_stall) begin
        if (i_branch_flag) begin
          r_pend_valid  <= 1'b1;
          r_pend_target <= i_branch_target;
        end
      end else begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Next fetch address: flush > stall > branch > pending > sequential.
  always_comb begin
    w_next_pc = i_pc + ADDR_W'(4);
    if (i_flush) begin
      w_next_pc = i_new_pc;
    end else if (i_stall) begin
      w_next_pc = i_pc;
    end else if (i_branch_flag) begin
      w_next_pc = i_branch_target;
    end else if (r_pend_valid) begin
      w_next_pc = r_pend_target;
    end
  end

  assign o_next_pc    = w_next_pc;
  assign o_pend_valid = r_pend_valid;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch address generator with stall, branch redirect and exception flush
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_pc_unit_if.slave       bus
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_if_pc;
  logic              r_if_valid;
  logic              r_addr_err;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_pend_valid;
  logic              w_run;

  assign w_run = (r_state == FETCH_RUN);

  fetch_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk             (clk),
    .rst             (rst),
    .i_run           (w_run),
    .i_stall         (bus.stall),
    .i_flush         (bus.flush),
    .i_new_pc        (bus.new_pc),
    .i_branch_flag   (bus.branch_flag),
    .i_branch_target (bus.branch_target),
    .i_pc            (r_pc),
    .o_next_pc       (w_next_pc),
    .o_pend_valid    (w_pend_valid)
  );

  // Fetch FSM: IDLE holds the ROM off for one cycle after reset, RUN advances
  // pc and registers the IF/ID-side view of the address the ROM is reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH_IDLE;
      r_pc       <= RESET_PC;
      r_if_pc    <= ADDR_W'(ZERO_WORD);
      r_if_valid <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          r_state    <= FETCH_RUN;
          r_if_valid <= 1'b0;
        end
        FETCH_RUN: begin
          r_pc       <= w_next_pc;
          r_if_pc    <= r_pc;
          r_addr_err <= addr_misaligned(r_pc[1:0]);
          r_if_valid <= ~bus.flush;
        end
        default: begin
          r_state    <= FETCH_IDLE;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc         = r_pc;
  assign bus.ce         = w_run;
  assign bus.if_pc      = r_if_pc;
  assign bus.if_valid   = r_if_valid;
  assign bus.addr_err   = r_addr_err;
  assign bus.pend_valid = w_pend_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed table-driven bench for fetch_pc_unit
module tb_fetch_pc_unit;

  logic clk;
  logic rst;

  fetch_pc_unit_if #(.ADDR_W(32)) bus ();

  fetch_pc_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bflag;
    logic [31:0] btarget;
    logic [31:0] e_pc;
    logic [31:0] e_if_pc;
    logic        e_valid;
    logic        e_aerr;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fails;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] np,
                       input logic b, input logic [31:0] bt);
    bus.stall         = s;
    bus.flush         = f;
    bus.new_pc        = np;
    bus.branch_flag   = b;
    bus.branch_target = bt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic f, input logic [31:0] np,
                     input logic b, input logic [31:0] bt,
                     input logic [31:0] pc, input logic [31:0] ipc,
                     input logic v, input logic ae, input logic pv);
    vec_t r;
    r.stall = s; r.flush = f; r.new_pc = np; r.bflag = b; r.btarget = bt;
    r.e_pc = pc; r.e_if_pc = ipc; r.e_valid = v; r.e_aerr = ae; r.e_pend = pv;
    vecs.push_back(r);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    //   stall flush new_pc      br  target         pc             if_pc          v  ae pend
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_000C, 32'h0000_0008, 1, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0010, 32'h0000_000C, 1, 0, 0);
    add(0, 0, 32'h0,          1, 32'h0000_0100,  32'h0000_0100, 32'h0000_0010, 1, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0104, 32'h0000_0100, 1, 0, 0);
    add(0, 0, 32'h0,          1, 32'h0000_0020,  32'h0000_0020, 32'h0000_0104, 1, 0, 0);
    add(1, 0, 32'h0,          1, 32'h0000_0200,  32'h0000_0020, 32'h0000_0020, 1, 0, 1);
    add(1, 0, 32'h0,          0, 32'h0,          32'h0000_0020, 32'h0000_0020, 1, 0, 1);
    add(1, 0, 32'h0,          0, 32'h0,          32'h0000_0020, 32'h0000_0020, 1, 0, 1);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0200, 32'h0000_0020, 1, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0204, 32'h0000_0200, 1, 0, 0);
    add(1, 0, 32'h0,          1, 32'h0000_0300,  32'h0000_0204, 32'h0000_0204, 1, 0, 1);
    add(1, 1, 32'h0000_0380,  0, 32'h0,          32'h0000_0380, 32'h0000_0204, 0, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0384, 32'h0000_0380, 1, 0, 0);
    add(1, 0, 32'h0,          1, 32'h0000_0400,  32'h0000_0384, 32'h0000_0384, 1, 0, 1);
    add(1, 0, 32'h0,          1, 32'h0000_0500,  32'h0000_0384, 32'h0000_0384, 1, 0, 1);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0500, 32'h0000_0384, 1, 0, 0);
    add(0, 1, 32'h0000_0600,  0, 32'h0,          32'h0000_0600, 32'h0000_0500, 0, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0604, 32'h0000_0600, 1, 0, 0);
    add(0, 0, 32'h0,          1, 32'h0000_0102,  32'h0000_0102, 32'h0000_0604, 1, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0106, 32'h0000_0102, 1, 1, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_010A, 32'h0000_0106, 1, 1, 0);
    add(0, 0, 32'h0,          1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0000_010A, 1, 1, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0004, 32'h0000_0000, 1, 0, 0);
    add(1, 0, 32'h0,          1, 32'h0000_0700,  32'h0000_0004, 32'h0000_0004, 1, 0, 1);
    add(0, 0, 32'h0,          1, 32'h0000_0800,  32'h0000_0800, 32'h0000_0004, 1, 0, 0);
    add(0, 0, 32'h0,          0, 32'h0,          32'h0000_0804, 32'h0000_0800, 1, 0, 0);

    // Reset held for three edges: ROM disabled, pc at reset value.
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d ce", i), {31'b0, bus.ce}, 32'd0);
      check($sformatf("rst%0d pc", i), bus.pc, 32'h0);
      check($sformatf("rst%0d if_valid", i), {31'b0, bus.if_valid}, 32'd0);
      check($sformatf("rst%0d pend", i), {31'b0, bus.pend_valid}, 32'd0);
    end

    // Release: first fetch is RESET_PC, if_valid trails ce by one cycle.
    rst = 1'b0;
    step();
    check("rel ce", {31'b0, bus.ce}, 32'd1);
    check("rel pc", bus.pc, 32'h0);
    check("rel if_valid", {31'b0, bus.if_valid}, 32'd0);
    step();
    check("run1 pc", bus.pc, 32'h4);
    check("run1 if_pc", bus.if_pc, 32'h0);
    check("run1 if_valid", {31'b0, bus.if_valid}, 32'd1);
    step();
    check("run2 pc", bus.pc, 32'h8);
    check("run2 if_pc", bus.if_pc, 32'h4);

    foreach (vecs[k]) begin
      drive(vecs[k].stall, vecs[k].flush, vecs[k].new_pc, vecs[k].bflag, vecs[k].btarget);
      step();
      check($sformatf("v%0d pc", k), bus.pc, vecs[k].e_pc);
      check($sformatf("v%0d if_pc", k), bus.if_pc, vecs[k].e_if_pc);
      check($sformatf("v%0d if_valid", k), {31'b0, bus.if_valid}, {31'b0, vecs[k].e_valid});
      check($sformatf("v%0d addr_err", k), {31'b0, bus.addr_err}, {31'b0, vecs[k].e_aerr});
      check($sformatf("v%0d pend", k), {31'b0, bus.pend_valid}, {31'b0, vecs[k].e_pend});
      check($sformatf("v%0d ce", k), {31'b0, bus.ce}, 32'd1);
    end

    // Reset mid-stall with an occupied redirect buffer.
    drive(1, 0, 32'h0, 1, 32'h0000_0900);
    step();
    check("mid pend set", {31'b0, bus.pend_valid}, 32'd1);
    check("mid pc held", bus.pc, 32'h0000_0804);
    rst = 1'b1;
    step();
    check("mid rst ce", {31'b0, bus.ce}, 32'd0);
    check("mid rst pc", bus.pc, 32'h0);
    check("mid rst if_pc", bus.if_pc, 32'h0);
    check("mid rst if_valid", {31'b0, bus.if_valid}, 32'd0);
    check("mid rst addr_err", {31'b0, bus.addr_err}, 32'd0);
    check("mid rst pend", {31'b0, bus.pend_valid}, 32'd0);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    step();
    check("restart ce", {31'b0, bus.ce}, 32'd1);
    check("restart pc", bus.pc, 32'h0);
    check("restart if_valid", {31'b0, bus.if_valid}, 32'd0);
    step();
    check("restart2 pc", bus.pc, 32'h4);
    check("restart2 if_pc", bus.if_pc, 32'h0);
    check("restart2 if_valid", {31'b0, bus.if_valid}, 32'd1);
    check("restart2 pend", {31'b0, bus.pend_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
